rob_store_commit: RTL and testbench

Parametrised reorder buffer successor for the out-of-order RISC-V core. It sits between Dispatcher, CDB, register file, LSB, IF and branch predictor. Depth is configurable and results arrive on NUM_CDB write-back ports. Commit is in order, one entry per cycle; stores commit through an explicit valid/ready handshake with the LSB, and every mispredict produces a single redirect-plus-flush event.

---
 rtl/rob_pkg.sv | 29 ++
 rtl/rob_cdb_match.sv | 29 ++
 rtl/rob_store_commit.sv | 255 +++++++++++++++++++++++++
 tb/tb_rob_store_commit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types for the store-commit reorder buffer: op-type encoding and the
// per-entry record held in the buffer.
package rob_pkg;

  typedef enum logic [2:0] {
    EMPTY    = 3'd0,
    REGISTER = 3'd1,
    BRANCH   = 3'd2,
    JALR     = 3'd3,
    STORE    = 3'd4
  } rob_op_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_op_e     op_type;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alt_pc;
    logic        pred_taken;
    logic [31:0] data;
  } rob_entry_t;

  // A branch resolved in the opposite direction to its prediction.
  function automatic logic is_mispredict(input logic taken, input logic pred);
    return taken != pred;
  endfunction

endpackage

// File: rtl/rob_cdb_match.sv
// Combinational CDB lookup for one buffer index: reports whether any
// write-back port targets the index and selects that port's result, with the
// lowest-numbered port taking priority.
module rob_cdb_match #(
  parameter int unsigned ROB_WIDTH = 3,
  parameter int unsigned NUM_CDB   = 2
) (
  input  logic [ROB_WIDTH-1:0]         i_index,
  input  logic [NUM_CDB-1:0]           i_cdb_valid,
  input  logic [NUM_CDB*ROB_WIDTH-1:0] i_cdb_index,
  input  logic [NUM_CDB*32-1:0]        i_cdb_data,
  output logic                         o_hit,
  output logic [31:0]                  o_data
);

  // Scan from the highest port down so the lowest matching port is written last.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int unsigned p = NUM_CDB; p > 0; p--) begin
      if (i_cdb_valid[p-1] &&
          (i_cdb_index[(p-1)*ROB_WIDTH +: ROB_WIDTH] == i_index)) begin
        o_hit  = 1'b1;
        o_data = i_cdb_data[(p-1)*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/rob_store_commit.sv
// Reorder buffer with in-order single-entry commit, LSB store handshake and
// a one-cycle redirect-plus-flush on branch mispredict.
// Optional: define ROB_QUERY_BYPASS_EN to add the two-port combinational
// operand lookup (q_index / q_ready / q_data) with CDB forwarding.
module rob_store_commit
  import rob_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = 3,
  parameter int unsigned NUM_CDB   = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         disp_valid,
  input  logic [2:0]                   disp_op_type,
  input  logic [4:0]                   disp_rd,
  input  logic [31:0]                  disp_pc,
  input  logic [31:0]                  disp_alt_pc,
  input  logic                         disp_pred_taken,
  input  logic                         disp_ready,
  input  logic [31:0]                  disp_data,
  output logic                         rob_full,
  output logic                         rob_empty,
  output logic [ROB_WIDTH:0]           rob_count,
  output logic [ROB_WIDTH-1:0]         alloc_index,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_WIDTH-1:0] cdb_index,
  input  logic [NUM_CDB*32-1:0]        cdb_data,
  output logic                         rf_en,
  output logic [4:0]                   rf_reg,
  output logic [ROB_WIDTH-1:0]         rf_index,
  output logic [31:0]                  rf_data,
  output logic                         st_valid,
  output logic [ROB_WIDTH-1:0]         st_index,
  input  logic                         st_ready,
  output logic                         redirect_en,
  output logic [31:0]                  redirect_pc,
`ifdef ROB_QUERY_BYPASS_EN
  input  logic [2*ROB_WIDTH-1:0]       q_index,
  output logic [1:0]                   q_ready,
  output logic [63:0]                  q_data,
`endif
  output logic                         flush_out,
  output logic                         bp_en,
  output logic [31:0]                  bp_pc,
  output logic                         bp_taken
);

  localparam int unsigned DEPTH = 1 << ROB_WIDTH;

  rob_entry_t           r_rob [DEPTH];
  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;
  logic                 r_flush;

  rob_entry_t           w_head;
  logic                 w_head_ok;
  logic                 w_disp;
  logic                 w_commit;
  logic [DEPTH-1:0]     w_hit;
  logic [31:0]          w_hit_data [DEPTH];

  logic                 w_rf_en;
  logic [4:0]           w_rf_reg;
  logic [31:0]          w_rf_data;
  logic                 w_redirect_en;
  logic [31:0]          w_redirect_pc;
  logic                 w_bp_en;
  logic [31:0]          w_bp_pc;
  logic                 w_bp_taken;
  logic                 w_flush;

  assign rob_count   = r_count;
  assign rob_full    = (r_count == (ROB_WIDTH+1)'(DEPTH));
  assign rob_empty   = (r_count == '0);
  assign alloc_index = r_tail;
  assign flush_out   = r_flush;

  assign w_head    = r_rob[r_head];
  assign w_head_ok = w_head.busy && w_head.ready && !r_flush;
  assign st_valid  = w_head_ok && (w_head.op_type == STORE);
  assign st_index  = r_head;
  // Stores leave only on an edge where the LSB accepts them.
  assign w_commit  = rdy_in && w_head_ok && ((w_head.op_type != STORE) || st_ready);
  assign w_disp    = rdy_in && !r_flush && disp_valid && !rob_full;

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    rob_cdb_match #(
      .ROB_WIDTH (ROB_WIDTH),
      .NUM_CDB   (NUM_CDB)
    ) u_match (
      .i_index     (ROB_WIDTH'(g)),
      .i_cdb_valid (cdb_valid),
      .i_cdb_index (cdb_index),
      .i_cdb_data  (cdb_data),
      .o_hit       (w_hit[g]),
      .o_data      (w_hit_data[g])
    );
  end

  // Decode the head entry into next-cycle commit pulses.
  always_comb begin
    w_rf_en       = 1'b0;
    w_rf_reg      = '0;
    w_rf_data     = '0;
    w_redirect_en = 1'b0;
    w_redirect_pc = '0;
    w_bp_en       = 1'b0;
    w_bp_pc       = '0;
    w_bp_taken    = 1'b0;
    w_flush       = 1'b0;
    if (w_commit) begin
      case (w_head.op_type)
        REGISTER: begin
          w_rf_en   = 1'b1;
          w_rf_reg  = w_head.rd;
          w_rf_data = w_head.data;
        end
        JALR: begin
          w_rf_en       = 1'b1;
          w_rf_reg      = w_head.rd;
          w_rf_data     = w_head.pc + 32'd4;
          w_redirect_en = 1'b1;
          w_redirect_pc = w_head.data;
        end
        BRANCH: begin
          w_bp_en    = 1'b1;
          w_bp_pc    = w_head.pc;
          w_bp_taken = w_head.data[0];
          if (is_mispredict(w_head.data[0], w_head.pred_taken)) begin
            w_redirect_en = 1'b1;
            w_redirect_pc = w_head.alt_pc;
            w_flush       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Entry storage: CDB completion, dispatch at the tail, retire at the head.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_rob[i] <= '0;
    end else if (rdy_in) begin
      if (r_flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_rob[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (r_rob[i].busy && w_hit[i]) begin
            r_rob[i].ready <= 1'b1;
            r_rob[i].data  <= w_hit_data[i];
          end
        end
        if (w_disp) begin
          r_rob[r_tail] <= '{busy:       1'b1,
                             ready:      disp_ready,
                             op_type:    rob_op_e'(disp_op_type),
                             rd:         disp_rd,
                             pc:         disp_pc,
                             alt_pc:     disp_alt_pc,
                             pred_taken: disp_pred_taken,
                             data:       disp_data};
        end
        // Placed after the CDB loop so a late CDB hit on the head cannot revive it.
        if (w_commit) begin
          r_rob[r_head].busy  <= 1'b0;
          r_rob[r_head].ready <= 1'b0;
        end
      end
    end
  end

  // Head/tail pointers, occupancy count and the one-cycle flush flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_flush <= 1'b0;
    end else if (rdy_in) begin
      if (r_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_flush <= 1'b0;
      end else begin
        if (w_disp)   r_tail <= r_tail + 1'b1;
        if (w_commit) r_head <= r_head + 1'b1;
        case ({w_disp, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: ;
        endcase
        r_flush <= w_flush;
      end
    end
  end

  // Registered commit pulses toward RF, IF and branch predictor.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rf_en       <= 1'b0;
      rf_reg      <= '0;
      rf_index    <= '0;
      rf_data     <= '0;
      redirect_en <= 1'b0;
      redirect_pc <= '0;
      bp_en       <= 1'b0;
      bp_pc       <= '0;
      bp_taken    <= 1'b0;
    end else if (rdy_in) begin
      rf_en       <= w_rf_en;
      rf_reg      <= w_rf_reg;
      rf_index    <= w_rf_en ? r_head : '0;
      rf_data     <= w_rf_data;
      redirect_en <= w_redirect_en;
      redirect_pc <= w_redirect_pc;
      bp_en       <= w_bp_en;
      bp_pc       <= w_bp_pc;
      bp_taken    <= w_bp_taken;
    end
  end

`ifdef ROB_QUERY_BYPASS_EN
  for (genvar k = 0; k < 2; k++) begin : g_query
    logic [ROB_WIDTH-1:0] w_q_idx;
    logic                 w_q_hit;
    logic [31:0]          w_q_cdb;
    logic                 w_q_busy;
    logic                 w_q_fwd;

    assign w_q_idx  = q_index[k*ROB_WIDTH +: ROB_WIDTH];
    assign w_q_busy = r_rob[w_q_idx].busy;
    assign w_q_fwd  = w_q_busy && w_q_hit && !r_flush;

    rob_cdb_match #(
      .ROB_WIDTH (ROB_WIDTH),
      .NUM_CDB   (NUM_CDB)
    ) u_qmatch (
      .i_index     (w_q_idx),
      .i_cdb_valid (cdb_valid),
      .i_cdb_index (cdb_index),
      .i_cdb_data  (cdb_data),
      .o_hit       (w_q_hit),
      .o_data      (w_q_cdb)
    );

    assign q_ready[k]         = w_q_busy && (r_rob[w_q_idx].ready || w_q_fwd);
    assign q_data[k*32 +: 32] = w_q_fwd ? w_q_cdb : r_rob[w_q_idx].data;
  end
`endif

endmodule

// File: tb/tb_rob_store_commit.sv
// Directed bench for rob_store_commit with a commit-event scoreboard.
module tb_rob_store_commit;
  import rob_pkg::*;

  localparam int unsigned RW = 3;
  localparam int unsigned NC = 2;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in;
  logic              disp_valid, disp_pred_taken, disp_ready;
  logic [2:0]        disp_op_type;
  logic [4:0]        disp_rd;
  logic [31:0]       disp_pc, disp_alt_pc, disp_data;
  logic              rob_full, rob_empty;
  logic [RW:0]       rob_count;
  logic [RW-1:0]     alloc_index;
  logic [NC-1:0]     cdb_valid;
  logic [NC*RW-1:0]  cdb_index;
  logic [NC*32-1:0]  cdb_data;
  logic              rf_en;
  logic [4:0]        rf_reg;
  logic [RW-1:0]     rf_index;
  logic [31:0]       rf_data;
  logic              st_valid, st_ready;
  logic [RW-1:0]     st_index;
  logic              redirect_en, flush_out, bp_en, bp_taken;
  logic [31:0]       redirect_pc, bp_pc;
`ifdef ROB_QUERY_BYPASS_EN
  logic [2*RW-1:0]   q_index = '0;
  logic [1:0]        q_ready;
  logic [63:0]       q_data;
`endif

  typedef struct packed {
    logic          rf_en;
    logic [4:0]    rd;
    logic [RW-1:0] idx;
    logic [31:0]   rf_data;
    logic          re;
    logic [31:0]   rpc;
    logic          bp;
    logic [31:0]   bpc;
    logic          bt;
    logic          fl;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  always #5 clk_in = ~clk_in;

  rob_store_commit #(.ROB_WIDTH(RW), .NUM_CDB(NC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_op_type(disp_op_type), .disp_rd(disp_rd),
    .disp_pc(disp_pc), .disp_alt_pc(disp_alt_pc), .disp_pred_taken(disp_pred_taken),
    .disp_ready(disp_ready), .disp_data(disp_data),
    .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count),
    .alloc_index(alloc_index),
    .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_data(cdb_data),
    .rf_en(rf_en), .rf_reg(rf_reg), .rf_index(rf_index), .rf_data(rf_data),
    .st_valid(st_valid), .st_index(st_index), .st_ready(st_ready),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
`ifdef ROB_QUERY_BYPASS_EN
    .q_index(q_index), .q_ready(q_ready), .q_data(q_data),
`endif
    .flush_out(flush_out), .bp_en(bp_en), .bp_pc(bp_pc), .bp_taken(bp_taken)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] pc,
                      input logic [31:0] alt, input logic pred, input logic rdy,
                      input logic [31:0] data);
    disp_valid = 1'b1; disp_op_type = op; disp_rd = rd; disp_pc = pc;
    disp_alt_pc = alt; disp_pred_taken = pred; disp_ready = rdy; disp_data = data;
    step();
    disp_valid = 1'b0;
  endtask

  task automatic cdb1(input logic [RW-1:0] idx, input logic [31:0] data);
    logic [RW-1:0] zi;
    zi = '0;
    cdb_valid = 2'b01; cdb_index = {zi, idx}; cdb_data = {32'h0, data};
    step();
    cdb_valid = '0;
  endtask

  function automatic void push_rf(input logic [4:0] rd, input logic [RW-1:0] idx,
                                  input logic [31:0] d);
    ev_t e;
    e = '0; e.rf_en = 1'b1; e.rd = rd; e.idx = idx; e.rf_data = d;
    sb.push_back(e);
  endfunction

  // Scoreboard: every commit pulse must match the oldest expected event.
  always @(negedge clk_in) begin
    if (!rst_in && (rf_en || bp_en || redirect_en || flush_out)) begin
      if (sb.size() == 0) begin
        check("spurious_event", {60'h0, rf_en, bp_en, redirect_en, flush_out}, 64'h0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("rf_en", rf_en, e.rf_en);
        if (e.rf_en) check("rf_fields", {rf_reg, rf_index, rf_data}, {e.rd, e.idx, e.rf_data});
        check("redirect_en", redirect_en, e.re);
        if (e.re) check("redirect_pc", redirect_pc, e.rpc);
        check("bp_en", bp_en, e.bp);
        if (e.bp) check("bp_fields", {bp_pc, bp_taken}, {e.bpc, e.bt});
        check("flush_out", flush_out, e.fl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [RW-1:0] eh, et;
    logic [4:0]    rd_at [8];
    logic [4:0]    rd;
    logic [31:0]   d;
    ev_t           e;
    int            n;

    rst_in = 1'b1; rdy_in = 1'b1; st_ready = 1'b0;
    disp_valid = 1'b0; disp_op_type = '0; disp_rd = '0; disp_pc = '0; disp_alt_pc = '0;
    disp_pred_taken = 1'b0; disp_ready = 1'b0; disp_data = '0;
    cdb_valid = '0; cdb_index = '0; cdb_data = '0;
    step(); step();
    rst_in = 1'b0;
    check("reset_empty", rob_empty, 1);
    check("reset_full", rob_full, 0);
    check("reset_count", rob_count, 0);
    check("reset_alloc", alloc_index, 0);
    check("reset_pulses", {rf_en, redirect_en, bp_en, flush_out, st_valid}, 0);

    // Fill with eight not-ready entries, then a dispatch that must be dropped.
    for (int i = 0; i < 8; i++) disp(REGISTER, 5'(i + 1), 32'h1000 + 32'(4 * i), 0, 0, 0, 0);
    check("fill_full", rob_full, 1);
    check("fill_count", rob_count, 8);
    check("fill_alloc", alloc_index, 0);
    disp(REGISTER, 5'd31, 32'hFFF0, 0, 0, 1, 32'hFFFF);
    check("over_count", rob_count, 8);
    check("over_alloc", alloc_index, 0);

    // Both ports in one cycle on different indices.
    push_rf(5'd1, 3'd0, 32'hBBBB0000);
    push_rf(5'd2, 3'd1, 32'hAAAA0001);
    cdb_valid = 2'b11; cdb_index = {3'd0, 3'd1}; cdb_data = {32'hBBBB0000, 32'hAAAA0001};
    step();
    // Both ports on the same index: port 0 must win.
    push_rf(5'd3, 3'd2, 32'h22220000);
    cdb_valid = 2'b11; cdb_index = {3'd2, 3'd2}; cdb_data = {32'h33330000, 32'h22220000};
    step();
    // Remaining entries through port 1 alone.
    for (int k = 3; k < 8; k++) begin
      push_rf(5'(k + 1), 3'(k), 32'hC0000000 + 32'(k));
      cdb_valid = 2'b10; cdb_index = {3'(k), 3'd0}; cdb_data = {32'hC0000000 + 32'(k), 32'h0};
      step();
    end
    cdb_valid = '0;
    repeat (3) step();
    check("drain_empty", rob_empty, 1);
    check("drain_alloc", alloc_index, 0);

    // A CDB write to an idle entry must not mark a later occupant ready.
    cdb1(3'd1, 32'hDEAD);
    disp(REGISTER, 5'd9, 32'h2000, 0, 0, 0, 0);
    disp(REGISTER, 5'd10, 32'h2004, 0, 0, 0, 0);
    push_rf(5'd9, 3'd0, 32'h900);
    cdb1(3'd0, 32'h900);
    step(); step();
    check("stale_cdb_count", rob_count, 1);
    push_rf(5'd10, 3'd1, 32'hA00);
    cdb1(3'd1, 32'hA00);
    step();
    check("stale_cdb_empty", rob_empty, 1);

    // Store held at the head while the LSB is not ready.
    st_ready = 1'b0;
    disp(STORE, 5'd0, 32'h300, 0, 0, 1, 32'h55);
    for (int c = 0; c < 3; c++) begin
      check("store_stall_valid", st_valid, 1);
      check("store_stall_index", st_index, 2);
      check("store_stall_count", rob_count, 1);
      step();
    end
    st_ready = 1'b1;
    check("store_accept_valid", st_valid, 1);
    step();
    st_ready = 1'b0;
    check("store_retired_valid", st_valid, 0);
    check("store_retired_count", rob_count, 0);

    // Mispredicted branch followed by a ready entry that must be flushed.
    disp(BRANCH, 5'd0, 32'h100, 32'h104, 1, 0, 0);
    disp(REGISTER, 5'd11, 32'h104, 0, 0, 1, 32'h1111);
    e = '0; e.bp = 1'b1; e.bpc = 32'h100; e.bt = 1'b0; e.re = 1'b1; e.rpc = 32'h104; e.fl = 1'b1;
    sb.push_back(e);
    cdb1(3'd3, 32'h0);
    step();
    check("flush_high", flush_out, 1);
    check("flush_count", rob_count, 1);
    disp(REGISTER, 5'd12, 32'h108, 0, 0, 1, 32'h1212);
    check("flush_done", flush_out, 0);
    check("flush_empty", rob_empty, 1);
    check("flush_count0", rob_count, 0);
    check("flush_alloc", alloc_index, 0);
    step();
    check("flush_dispatch_dropped", rob_empty, 1);

    // Correctly predicted taken branch: predictor update only.
    e = '0; e.bp = 1'b1; e.bpc = 32'h180; e.bt = 1'b1;
    sb.push_back(e);
    disp(BRANCH, 5'd0, 32'h180, 32'h999, 1, 1, 32'h1);
    step();
    check("branch_ok_empty", rob_empty, 1);

    // JALR with a two-cycle pause before it may commit.
    disp(JALR, 5'd5, 32'h200, 0, 0, 0, 0);
    cdb1(3'd1, 32'h300);
    rdy_in = 1'b0;
    step(); step();
    check("freeze_count", rob_count, 1);
    check("freeze_rf_en", rf_en, 0);
    e = '0; e.rf_en = 1'b1; e.rd = 5'd5; e.idx = 3'd1; e.rf_data = 32'h204;
    e.re = 1'b1; e.rpc = 32'h300;
    sb.push_back(e);
    rdy_in = 1'b1;
    step(); step();
    check("jalr_empty", rob_empty, 1);

    // Keep the buffer at full occupancy across index wrap.
    eh = 3'd2; et = 3'd2; n = 0;
    for (int i = 0; i < 8; i++) begin
      rd = 5'(n + 1);
      rd_at[et] = rd;
      disp(REGISTER, rd, 32'h4000 + 32'(4 * n), 0, 0, 0, 0);
      et = et + 1'b1; n++;
    end
    check("wrap_fill_full", rob_full, 1);
    for (int it = 0; it < 20; it++) begin
      d = 32'h50000000 + 32'(it);
      push_rf(rd_at[eh], eh, d);
      cdb1(eh, d);
      check("wrap_count_full", rob_count, 8);
      rd = 5'(n + 1);
      disp_valid = 1'b1; disp_op_type = REGISTER; disp_rd = rd;
      disp_pc = 32'h4000 + 32'(4 * n); disp_ready = 1'b0; disp_data = '0;
      step();
      eh = eh + 1'b1;
      check("wrap_count_commit", rob_count, 7);
      check("wrap_alloc_blocked", alloc_index, et);
      step();
      disp_valid = 1'b0;
      rd_at[et] = rd;
      et = et + 1'b1; n++;
      check("wrap_alloc_adv", alloc_index, et);
    end
    check("wrap_end_count", rob_count, 8);

    repeat (3) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
